apb_coeff_bank: RTL and testbench

Parametrised APB3 slave holding double-buffered coefficient sets for `N_CH` filter channels, the next generation of the DFE coefficient/config register block.

- Software writes coefficients into a shadow bank.
- An atomic commit copies the shadow bank into the active bank. The commit comes from an APB write or a hardware frame strobe.
- Filters therefore never see a half-updated coefficient set.
- The block adds programmable wait states and PSLVERR over the previous generation, and sits between the APB bridge and the filter array.

---
 rtl/apb_coeff_bank.sv | 159 +++++++++++++++
 tb/tb_apb_coeff_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/apb_coeff_bank.sv
// APB3 slave holding double-buffered filter coefficients: software fills a shadow bank and an
// atomic commit (APB register write or hardware strobe) copies it into the active bank.
module apb_coeff_bank #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned PDATA_WIDTH = 32,
    parameter int unsigned COEFF_WIDTH = 20,
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              PSEL,
    input  logic                              PENABLE,
    input  logic                              PWRITE,
    input  logic [ADDR_WIDTH-1:0]             PADDR,
    input  logic [PDATA_WIDTH-1:0]            PWDATA,
    output logic [PDATA_WIDTH-1:0]            PRDATA,
    output logic                              PREADY,
    output logic                              PSLVERR,
    input  logic [N_CH-1:0]                   COMMIT_IN,
    output logic [N_CH*DEPTH*COEFF_WIDTH-1:0] COEFF_OUT,
    output logic [N_CH-1:0]                   COEFF_VLD,
    output logic [N_CH-1:0]                   DIRTY
);

    localparam int unsigned NumCoeff = N_CH * DEPTH;

    localparam logic [ADDR_WIDTH-1:0] AddrCommit = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] AddrStatus = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] AddrId     = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(1);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [COEFF_WIDTH-1:0] shadow_q [NumCoeff];
    logic [COEFF_WIDTH-1:0] shadow_d [NumCoeff];
    logic [COEFF_WIDTH-1:0] active_q [NumCoeff];
    logic [COEFF_WIDTH-1:0] active_d [NumCoeff];
    logic [N_CH-1:0]        dirty_q, dirty_d;
    logic [N_CH-1:0]        vld_q, vld_d;

    logic                   done;
    logic                   hit_coeff, hit_commit, hit_status, hit_id, addr_err;
    logic                   wr_coeff;
    logic [N_CH-1:0]        commit_mask, wr_ch;
    logic [PDATA_WIDTH-1:0] rd_data;

    // Address decode and read mux
    always_comb begin
        done       = (state_q == StAccess) && PSEL && PENABLE && (cnt_q == 3'd0);
        hit_coeff  = 32'(PADDR) < NumCoeff;
        hit_commit = PADDR == AddrCommit;
        hit_status = PADDR == AddrStatus;
        hit_id     = PADDR == AddrId;
        addr_err   = !(hit_coeff || hit_commit || hit_status || hit_id)
                     || (PWRITE && (hit_status || hit_id));
        rd_data    = '0;
        if (hit_coeff) begin
            for (int unsigned k = 0; k < NumCoeff; k++) begin
                if (PADDR == ADDR_WIDTH'(k)) begin
                    rd_data = PDATA_WIDTH'($signed(shadow_q[k]));
                end
            end
        end else if (hit_status) begin
            rd_data = PDATA_WIDTH'(dirty_q);
        end else if (hit_id) begin
            rd_data = PDATA_WIDTH'({8'hC0, 8'(N_CH), 8'(DEPTH), 8'(COEFF_WIDTH)});
        end
    end

    always_comb begin
        PREADY  = done;
        PSLVERR = done && addr_err;
        PRDATA  = (done && !addr_err && !PWRITE) ? rd_data : '0;
    end

    // Transfer FSM: a dropped PSEL before completion aborts with no side effect
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (PSEL && !PENABLE) begin
                    state_d = StAccess;
                    cnt_d   = 3'(WAIT_STATES);
                end
            end
            StAccess: begin
                if (!PSEL) begin
                    state_d = StIdle;
                end else if (PENABLE) begin
                    if (cnt_q != 3'd0) begin
                        cnt_d = cnt_q - 3'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bank update: commit copies the pre-write shadow, so a same-cycle write stays dirty
    always_comb begin
        wr_coeff    = done && PWRITE && hit_coeff;
        commit_mask = COMMIT_IN;
        if (done && PWRITE && hit_commit) begin
            commit_mask = commit_mask | PWDATA[N_CH-1:0];
        end
        shadow_d = shadow_q;
        active_d = active_q;
        wr_ch    = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (commit_mask[c]) begin
                    active_d[c*DEPTH+i] = shadow_q[c*DEPTH+i];
                end
                if (wr_coeff && (PADDR == ADDR_WIDTH'(c*DEPTH+i))) begin
                    shadow_d[c*DEPTH+i] = PWDATA[COEFF_WIDTH-1:0];
                    wr_ch[c]            = 1'b1;
                end
            end
        end
        dirty_d = (dirty_q & ~commit_mask) | wr_ch;
        vld_d   = commit_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dirty_q <= '0;
            vld_q   <= '0;
            for (int unsigned k = 0; k < NumCoeff; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dirty_q  <= dirty_d;
            vld_q    <= vld_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        COEFF_OUT = '0;
        for (int unsigned k = 0; k < NumCoeff; k++) begin
            COEFF_OUT[k*COEFF_WIDTH +: COEFF_WIDTH] = active_q[k];
        end
        COEFF_VLD = vld_q;
        DIRTY     = dirty_q;
    end

endmodule

// File: tb/tb_apb_coeff_bank.sv
// Directed bench for apb_coeff_bank with default parameters (4 ch x 16 coeffs, 1 wait state).
module tb_apb_coeff_bank;

    logic          clk = 1'b0;
    logic          rst;
    logic          PSEL, PENABLE, PWRITE;
    logic [7:0]    PADDR;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA;
    logic          PREADY, PSLVERR;
    logic [3:0]    COMMIT_IN;
    logic [1279:0] COEFF_OUT;
    logic [3:0]    COEFF_VLD;
    logic [3:0]    DIRTY;

    int errors = 0;
    int checks = 0;

    logic [31:0] rdata;
    logic        rerr;
    int          nacc;

    apb_coeff_bank dut (
        .clk       (clk),
        .rst       (rst),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .COMMIT_IN (COMMIT_IN),
        .COEFF_OUT (COEFF_OUT),
        .COEFF_VLD (COEFF_VLD),
        .DIRTY     (DIRTY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] coeff(input int c, input int i);
        return COEFF_OUT[(c*16+i)*20 +: 20];
    endfunction

    // One APB transfer; cin is pulsed on COMMIT_IN during the PREADY cycle.
    // Returns at posedge+1 of the cycle after completion.
    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                       input logic [3:0] cin);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        nacc = 0;
        rdata = 'x;
        rerr = 1'bx;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            nacc++;
            if (PREADY) begin
                rdata = PRDATA;
                rerr = PSLVERR;
                COMMIT_IN = cin;
                break;
            end
            @(posedge clk); #1;
        end
        if (!PREADY) begin
            chk("pready_timeout", 64'(nacc), 64'd0);
        end
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; COMMIT_IN = '0;
    endtask

    initial begin
        rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; COMMIT_IN = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready", 64'(PREADY), 64'd0);
        chk("rst_prdata", 64'(PRDATA), 64'd0);
        chk("rst_dirty", 64'(DIRTY), 64'd0);
        chk("rst_vld", 64'(COEFF_VLD), 64'd0);
        chk("rst_coeff_out", 64'(COEFF_OUT == '0), 64'd1);
        rst = 1'b0;

        // Reset lands on the completing edge of a write to addr 0: write must be dropped
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd0; PWDATA = 32'd9;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_pready", 64'(PREADY), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_pready", 64'(PREADY), 64'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        chk("post_rst_dirty", 64'(DIRTY), 64'd0);
        apb(1'b0, 8'd0, 32'd0, 4'd0);
        chk("post_rst_rd0", 64'(rdata), 64'd0);

        // Write/read with one wait state
        apb(1'b1, 8'd17, 32'h000FFFFE, 4'd0);
        chk("wr17_nacc", 64'(nacc), 64'd2);
        chk("wr17_err", 64'(rerr), 64'd0);
        chk("wr17_dirty", 64'(DIRTY), 64'h2);
        apb(1'b0, 8'd17, 32'd0, 4'd0);
        chk("rd17_data", 64'(rdata), 64'hFFFFFFFE);
        chk("rd17_nacc", 64'(nacc), 64'd2);
        chk("rd17_coeff_unchanged", 64'(coeff(1, 1)), 64'd0);

        // APB commit of channel 1
        apb(1'b1, 8'd252, 32'h2, 4'd0);
        chk("commit_vld", 64'(COEFF_VLD), 64'h2);
        chk("commit_ch1i1", 64'(coeff(1, 1)), 64'hFFFFE);
        chk("commit_dirty", 64'(DIRTY), 64'd0);
        @(posedge clk); #1;
        chk("commit_vld_1cyc", 64'(COEFF_VLD), 64'd0);

        // Simultaneous COMMIT_IN[0] and completing write to channel 0
        apb(1'b1, 8'd0, 32'd3, 4'd0);
        chk("pre_sim_dirty", 64'(DIRTY), 64'h1);
        apb(1'b1, 8'd0, 32'd5, 4'b0001);
        chk("sim_active", 64'(coeff(0, 0)), 64'd3);
        chk("sim_vld", 64'(COEFF_VLD), 64'h1);
        chk("sim_dirty", 64'(DIRTY), 64'h1);
        apb(1'b0, 8'd0, 32'd0, 4'd0);
        chk("sim_shadow", 64'(rdata), 64'd5);

        // Hardware strobe alone, then a clean channel commit
        @(posedge clk); #1;
        COMMIT_IN = 4'b0001;
        @(posedge clk); #1;
        COMMIT_IN = 4'b1000;
        chk("hw_active", 64'(coeff(0, 0)), 64'd5);
        chk("hw_vld", 64'(COEFF_VLD), 64'h1);
        chk("hw_dirty", 64'(DIRTY), 64'd0);
        @(posedge clk); #1;
        COMMIT_IN = '0;
        chk("clean_vld", 64'(COEFF_VLD), 64'h8);
        chk("clean_ch1_kept", 64'(coeff(1, 1)), 64'hFFFFE);

        // Error and register map
        apb(1'b0, 8'd100, 32'd0, 4'd0);
        chk("unmapped_err", 64'(rerr), 64'd1);
        chk("unmapped_data", 64'(rdata), 64'd0);
        apb(1'b1, 8'd254, 32'h12345678, 4'd0);
        chk("wr_id_err", 64'(rerr), 64'd1);
        apb(1'b0, 8'd254, 32'd0, 4'd0);
        chk("rd_id_err", 64'(rerr), 64'd0);
        chk("rd_id_data", 64'(rdata), 64'hC0041014);
        apb(1'b1, 8'd253, 32'hF, 4'd0);
        chk("wr_status_err", 64'(rerr), 64'd1);
        apb(1'b0, 8'd255, 32'd0, 4'd0);
        chk("rd_top1_err", 64'(rerr), 64'd1);
        apb(1'b0, 8'd252, 32'd0, 4'd0);
        chk("rd_commit_err", 64'(rerr), 64'd0);
        chk("rd_commit_data", 64'(rdata), 64'd0);
        apb(1'b1, 8'd63, 32'h00080000, 4'd0);
        chk("wr63_dirty", 64'(DIRTY), 64'h8);
        apb(1'b0, 8'd253, 32'd0, 4'd0);
        chk("rd_status", 64'(rdata), 64'h8);
        apb(1'b0, 8'd63, 32'd0, 4'd0);
        chk("rd63_sext", 64'(rdata), 64'hFFF80000);
        chk("rd63_err", 64'(rerr), 64'd0);

        // Abort: PSEL drops during the wait state of a write to addr 3
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd3; PWDATA = 32'd7;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(negedge clk);
        chk("abort_wait", 64'(PREADY), 64'd0);
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge clk); #1;
        chk("abort_dirty", 64'(DIRTY), 64'h8);
        apb(1'b0, 8'd3, 32'd0, 4'd0);
        chk("abort_rd3", 64'(rdata), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
